// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared fetch/decode constants for the IF/ID buffer
package if_id_buffer_pkg;

    localparam int DEFAULT_DEPTH  = 2;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [DEFAULT_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [DEFAULT_DATA_W-1:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/if_id_entry_ram.sv
// rtl/if_id_entry_ram.sv - entry storage: one synchronous write port, one asynchronous read port
module if_id_entry_ram #(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 1
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    // Left unreset: an entry is only read while the control logic counts it as valid.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - FIFO between fetch and decode holding instruction and PC+4
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        InInstruction,
    input  logic [DATA_W-1:0]        InPC,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [DATA_W-1:0]        OutInstruction,
    output logic [DATA_W-1:0]        OutPCPlus4,
    output logic                     OutValid,
    input  logic                     OutReady,
    input  logic                     Flush,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rd_instr;
    logic [DATA_W-1:0] rd_pc_plus4;

    // Ready depends only on the registered count, so OutReady never reaches InReady.
    assign InReady  = (count_q < CNT_W'(DEPTH));
    assign OutValid = (count_q != '0);
    assign Count    = count_q;

    assign push = InValid && InReady && !Flush;
    assign pop  = OutValid && OutReady && !Flush;

    assign pc_plus4 = InPC + DATA_W'(PC_INCR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_entry_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (2 * DATA_W),
        .ADDR_W (PTR_W)
    ) u_entry_ram (
        .clk_i     (Clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({pc_plus4, InInstruction}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o ({rd_pc_plus4, rd_instr})
    );

    // Empty buffer presents a NOP so decode never sees stale storage.
    assign OutInstruction = OutValid ? rd_instr    : DATA_W'(NOP_INSTR);
    assign OutPCPlus4     = OutValid ? rd_pc_plus4 : '0;

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - directed self-checking bench for if_id_buffer
module tb_if_id_buffer;

    logic        Clk;
    logic        Reset;
    logic [31:0] InInstruction;
    logic [31:0] InPC;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutInstruction;
    logic [31:0] OutPCPlus4;
    logic        OutValid;
    logic        OutReady;
    logic        Flush;
    logic [1:0]  Count;

    int n_checks;
    int n_fails;

    if_id_buffer #(
        .DEPTH  (2),
        .DATA_W (32)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .InInstruction  (InInstruction),
        .InPC           (InPC),
        .InValid        (InValid),
        .InReady        (InReady),
        .OutInstruction (OutInstruction),
        .OutPCPlus4     (OutPCPlus4),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .Flush          (Flush),
        .Count          (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] instr, input logic [31:0] pc);
        InValid       = 1'b1;
        InInstruction = instr;
        InPC          = pc;
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_count"},  32'(Count), 32'd0);
        check_eq({tag, "_ovalid"}, 32'(OutValid), 32'd0);
        check_eq({tag, "_oinstr"}, OutInstruction, 32'h0);
        check_eq({tag, "_opc4"},   OutPCPlus4, 32'h0);
        check_eq({tag, "_iready"}, 32'(InReady), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        Reset         = 1'b0;
        InInstruction = '0;
        InPC          = '0;
        InValid       = 1'b0;
        OutReady      = 1'b0;
        Flush         = 1'b0;

        // Reset held for two cycles, then released
        #1;
        check_empty("rst0");
        tick();
        tick();
        check_empty("rst2");
        Reset = 1'b1;
        tick();
        check_empty("rst_rel");

        // Single push with decode ready: visible next cycle, popped after
        OutReady = 1'b1;
        drive_push(32'h2010_0005, 32'h0000_0000);
        check_eq("single_no_bypass", 32'(OutValid), 32'd0);
        tick();
        InValid = 1'b0;
        check_eq("single_valid", 32'(OutValid), 32'd1);
        check_eq("single_instr", OutInstruction, 32'h2010_0005);
        check_eq("single_pc4",   OutPCPlus4, 32'h0000_0004);
        check_eq("single_count", 32'(Count), 32'd1);
        tick();
        check_eq("single_popped", 32'(Count), 32'd0);
        check_eq("single_empty",  32'(OutValid), 32'd0);

        // Fill to DEPTH with decode stalled; third push refused
        OutReady = 1'b0;
        drive_push(32'hA000_0000, 32'h0000_0000);
        tick();
        drive_push(32'hA000_0001, 32'h0000_0004);
        tick();
        drive_push(32'hA000_0002, 32'h0000_0008);
        check_eq("full_iready", 32'(InReady), 32'd0);
        check_eq("full_count",  32'(Count), 32'd2);
        tick();
        InValid = 1'b0;
        check_eq("full_count_hold", 32'(Count), 32'd2);
        check_eq("full_stall_pc4",  OutPCPlus4, 32'h0000_0004);
        check_eq("full_stall_instr", OutInstruction, 32'hA000_0000);
        OutReady = 1'b1;
        tick();
        check_eq("drain1_pc4",   OutPCPlus4, 32'h0000_0008);
        check_eq("drain1_instr", OutInstruction, 32'hA000_0001);
        check_eq("drain1_count", 32'(Count), 32'd1);
        tick();
        check_eq("drain2_count", 32'(Count), 32'd0);
        check_eq("drain2_valid", 32'(OutValid), 32'd0);

        // Push and pop on the same edge with one entry held
        OutReady = 1'b0;
        drive_push(32'hB000_0000, 32'h0000_0100);
        tick();
        check_eq("pp_pre_count", 32'(Count), 32'd1);
        drive_push(32'hB000_0001, 32'h0000_0200);
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        check_eq("pp_count", 32'(Count), 32'd1);
        check_eq("pp_instr", OutInstruction, 32'hB000_0001);
        check_eq("pp_pc4",   OutPCPlus4, 32'h0000_0204);
        tick();
        check_eq("pp_drain", 32'(Count), 32'd0);

        // Flush with a full buffer and a concurrent push
        OutReady = 1'b0;
        drive_push(32'hC000_0000, 32'h0000_0300);
        tick();
        drive_push(32'hC000_0001, 32'h0000_0304);
        tick();
        check_eq("fl_pre_count", 32'(Count), 32'd2);
        drive_push(32'hC000_0002, 32'h0000_0308);
        Flush    = 1'b1;
        OutReady = 1'b1;
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        check_empty("flush");
        tick();
        check_empty("flush_after");

        // PC+4 wraps at the top of the address space
        OutReady = 1'b0;
        drive_push(32'hD000_0000, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc4",   OutPCPlus4, 32'h0000_0000);
        check_eq("wrap_valid", 32'(OutValid), 32'd1);
        drive_push(32'hD000_0001, 32'h0000_0010);
        tick();
        InValid = 1'b0;
        check_eq("mid_pre_count", 32'(Count), 32'd2);

        // Asynchronous reset mid-cycle clears outputs before the next edge
        #2;
        Reset = 1'b0;
        #1;
        check_empty("async_rst");
        tick();
        Reset = 1'b1;
        tick();
        check_empty("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
